// File: rtl/control_movimiento_pkg.sv
// Shared encodings for the movement controller: FSM states and direction codes,
// plus the left/right arbitration rule used wherever both buttons are resolved.
package control_movimiento_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRIMERO = 2'b01,
    ESPERA  = 2'b10,
    REPITE  = 2'b11
  } estado_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10
  } dir_t;

  // A single pressed button selects its direction; none or both means no move.
  function automatic dir_t arbitrar(input logic i_der, input logic i_izq);
    dir_t w_dir;
    if (i_der && !i_izq) begin
      w_dir = DIR_RIGHT;
    end else if (i_izq && !i_der) begin
      w_dir = DIR_LEFT;
    end else begin
      w_dir = DIR_NONE;
    end
    return w_dir;
  endfunction

endpackage

// File: rtl/control_movimiento_antirrebote.sv
// Button conditioner: two-flop synchronizer followed by a debounce counter.
// The debounced level only changes after DEB_CYCLES consecutive cycles of a
// synchronized level that differs from it.
module antirrebote #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_nivel
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_nivel;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive mismatch cycles; flip the level once the run is long enough.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_nivel <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_nivel) begin
      r_cnt <= '0;
    end else if (r_cnt == DEB_LAST) begin
      r_nivel <= ~r_nivel;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_nivel = r_nivel;

endmodule

// File: rtl/control_movimiento.sv
// Movement controller: debounces the left/right buttons, arbitrates a single
// direction and runs a hold-to-repeat FSM that emits one-cycle der/izq strobes,
// suppressed when the position block reports no room on that side.
module control_movimiento
  import control_movimiento_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned REP_DELAY  = 12500000,
  parameter int unsigned REP_PERIOD = 2500000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnDer,
  input  logic       btnIzq,
  input  logic       espacioAr,
  input  logic       espacioAb,
  output logic       der,
  output logic       izq,
  output logic [1:0] dirActiva
);

  localparam logic [CNT_W-1:0] REP_DELAY_M1  = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_PERIOD_M1 = CNT_W'(REP_PERIOD - 1);

  logic             w_nivel_der;
  logic             w_nivel_izq;
  dir_t             w_dir;
  logic             w_strobe_der;
  logic             w_strobe_izq;

  estado_t          r_estado;
  dir_t             r_dir_lat;
  dir_t             r_dir_act;
  logic [CNT_W-1:0] r_rep;
  logic             r_der;
  logic             r_izq;

  antirrebote #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_antirrebote_der (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_btn  (btnDer),
    .o_nivel(w_nivel_der)
  );

  antirrebote #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_antirrebote_izq (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_btn  (btnIzq),
    .o_nivel(w_nivel_izq)
  );

  assign w_dir = arbitrar(w_nivel_der, w_nivel_izq);

  // Strobe values for the latched direction, gated by the field-edge flags.
  assign w_strobe_der = (r_dir_lat == DIR_RIGHT) && espacioAr;
  assign w_strobe_izq = (r_dir_lat == DIR_LEFT) && espacioAb;

  // Hold-to-repeat FSM with registered strobes and direction indicator.
  // A suppressed strobe still reloads the timer, so cadence never slips.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado  <= IDLE;
      r_dir_lat <= DIR_NONE;
      r_dir_act <= DIR_NONE;
      r_rep     <= '0;
      r_der     <= 1'b0;
      r_izq     <= 1'b0;
    end else begin
      r_der <= 1'b0;
      r_izq <= 1'b0;
      case (r_estado)
        IDLE: begin
          r_rep     <= '0;
          r_dir_act <= DIR_NONE;
          if (w_dir != DIR_NONE) begin
            r_estado  <= PRIMERO;
            r_dir_lat <= w_dir;
          end
        end
        default: begin
          if (w_dir != r_dir_lat) begin
            r_estado  <= IDLE;
            r_rep     <= '0;
            r_dir_act <= DIR_NONE;
          end else begin
            r_dir_act <= r_dir_lat;
            if (r_estado == PRIMERO) begin
              r_der    <= w_strobe_der;
              r_izq    <= w_strobe_izq;
              r_rep    <= REP_DELAY_M1;
              r_estado <= ESPERA;
            end else if (r_rep == '0) begin
              r_der    <= w_strobe_der;
              r_izq    <= w_strobe_izq;
              r_rep    <= REP_PERIOD_M1;
              r_estado <= REPITE;
            end else begin
              r_rep <= r_rep - CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign der       = r_der;
  assign izq       = r_izq;
  assign dirActiva = r_dir_act;

endmodule

// File: tb/tb_control_movimiento.sv
// Scoreboard bench for control_movimiento. A reference model derives the expected
// outputs from the raw inputs (sync delay, run-length debounce, strobe schedule
// from time since the move started) and queues them; a monitor compares each cycle.
module tb_control_movimiento;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int CW  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btnDer = 1'b0;
  logic       btnIzq = 1'b0;
  logic       espacioAr = 1'b1;
  logic       espacioAb = 1'b1;
  logic       der;
  logic       izq;
  logic [1:0] dirActiva;

  control_movimiento #(
    .DEB_CYCLES(DEB),
    .REP_DELAY (RD),
    .REP_PERIOD(RP),
    .CNT_W     (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btnDer   (btnDer),
    .btnIzq   (btnIzq),
    .espacioAr(espacioAr),
    .espacioAb(espacioAb),
    .der      (der),
    .izq      (izq),
    .dirActiva(dirActiva)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  bit         started = 0;
  bit         done = 0;
  int         cyc = 0;
  int         last_drive_edge = 0;
  bit         cap_en = 0;
  int         cap_base = 0;
  int         cap_q[$];
  logic [3:0] mon_a;
  logic [3:0] mon_e;

  // Reference model state: raw->sync pipeline, debounced levels, mismatch run
  // lengths, and the active move (direction, edges elapsed since it started).
  bit m_s1[2];
  bit m_s2[2];
  bit m_deb[2];
  int m_run[2];
  bit m_act;
  int m_ld;
  int m_k;

  task automatic model_step(input bit bd, input bit bi, input bit ea, input bit eb, input bit rst);
    int  dir;
    bit  od, oi, st;
    int  da;
    bit  raw[2];
    logic [1:0] da2;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
      end
      m_act = 0; m_ld = 0; m_k = 0;
      exp_q.push_back(4'b0000);
      return;
    end
    raw[0] = bd; raw[1] = bi;
    dir = (m_deb[0] && !m_deb[1]) ? 1 : ((m_deb[1] && !m_deb[0]) ? 2 : 0);
    od = 0; oi = 0; da = 0;
    if (!m_act) begin
      if (dir != 0) begin
        m_act = 1; m_ld = dir; m_k = 0;
      end
    end else if (dir != m_ld) begin
      m_act = 0;
    end else begin
      m_k++;
      da = m_ld;
      st = (m_k == 1) || ((m_k >= 1 + RD) && (((m_k - 1 - RD) % RP) == 0));
      if (st) begin
        od = (m_ld == 1) && ea;
        oi = (m_ld == 2) && eb;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_deb[i] = !m_deb[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
    da2 = da[1:0];
    exp_q.push_back({od, oi, da2});
  endtask

  task automatic step(input bit bd, input bit bi, input bit ea, input bit eb);
    @(negedge clk);
    reset = 1'b1; btnDer = bd; btnIzq = bi; espacioAr = ea; espacioAb = eb;
    model_step(bd, bi, ea, eb, 1'b1);
    last_drive_edge = cyc + 1;
    started = 1;
  endtask

  task automatic do_reset(input int n, input bit bd, input bit bi);
    @(negedge clk);
    reset = 1'b0; btnDer = bd; btnIzq = bi;
    model_step(bd, bi, 1'b1, 1'b1, 1'b0);
    started = 1;
    #1;
    checks++;
    if ({der, izq, dirActiva} !== 4'b0000)
      $display("FAIL async_reset t=%0t: got der=%b izq=%b dirActiva=%b, expected 0 0 00",
               $time, der, izq, dirActiva);
    if ({der, izq, dirActiva} !== 4'b0000) errors++;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      model_step(bd, bi, 1'b1, 1'b1, 1'b0);
    end
  endtask

  // Monitor: one expected output word per clock, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (started && !done) begin
        mon_a = {der, izq, dirActiva};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow cycle %0d: got %b, no expected value queued", cyc, mon_a);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_a !== mon_e) begin
            errors++;
            $display("FAIL outputs cycle %0d: got der=%b izq=%b dirActiva=%b, expected der=%b izq=%b dirActiva=%b",
                     cyc, mon_a[3], mon_a[2], mon_a[1:0], mon_e[3], mon_e[2], mon_e[1:0]);
          end
        end
        checks++;
        if (der === 1'b1 && izq === 1'b1) begin
          errors++;
          $display("FAIL exclusive cycle %0d: got der=1 izq=1, expected at most one high", cyc);
        end
        if (cap_en && der === 1'b1) cap_q.push_back(cyc - cap_base);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_t[6];
    int got_t[$];
    exp_t = '{7, 17, 20, 23, 26, 29};

    do_reset(3, 1'b0, 1'b0);

    // Clean right press held 30 cycles; strobe cycles also checked against fixed times.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    cap_base = last_drive_edge;
    cap_en = 1;
    repeat (29) step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b1, 1'b1);
    cap_en = 0;
    foreach (cap_q[i]) if (cap_q[i] <= 29) got_t.push_back(cap_q[i]);
    checks++;
    if (got_t.size() != 6) begin
      errors++;
      $display("FAIL clean_press_count: got %0d der strobes in cycles 0..29, expected 6", got_t.size());
    end
    for (int i = 0; i < 6 && i < got_t.size(); i++) begin
      checks++;
      if (got_t[i] != exp_t[i]) begin
        errors++;
        $display("FAIL clean_press_time[%0d]: got cycle %0d, expected cycle %0d", i, got_t[i], exp_t[i]);
      end
    end

    // Left held with the left edge blocked for cycles 15..21.
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b1, (i < 15) || (i >= 22));
    repeat (15) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Bouncing left button, every 2 cycles for 12 cycles.
    for (int i = 0; i < 12; i++) step(1'b0, ((i / 2) % 2) == 0, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Right held, left added at cycle 12, right released at 30.
    for (int i = 0; i < 45; i++) step(i < 30, i >= 12, 1'b1, 1'b1);
    repeat (15) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Reset mid-repeat with right held.
    repeat (18) step(1'b1, 1'b0, 1'b1, 1'b1);
    do_reset(2, 1'b1, 1'b0);
    repeat (15) step(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (15) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Short release of 3 cycles at cycle 19.
    for (int i = 0; i < 35; i++) step((i < 19) || (i >= 22), 1'b0, 1'b1, 1'b1);
    repeat (15) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Randomized phases.
    for (int p = 0; p < 70; p++) begin
      int n, n2, kind, which, per, g;
      bit bd, bi, lv;
      kind  = $urandom_range(0, 5);
      n     = $urandom_range(5, 40);
      n2    = $urandom_range(3, 25);
      which = $urandom_range(0, 2);
      bd    = (which != 1);
      bi    = (which != 0);
      case (kind)
        0: repeat (n) step(bd, bi, 1'b1, 1'b1);
        1: begin
          per = $urandom_range(1, 3);
          lv  = 1'b0;
          for (int i = 0; i < 12; i++) begin
            if ((i % per) == 0) lv = !lv;
            step(bd && lv, bi && lv, 1'b1, 1'b1);
          end
        end
        2: repeat (n) step(bd, bi, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        3: begin
          g = $urandom_range(1, DEB - 1);
          repeat (n) step(bd, bi, 1'b1, 1'b1);
          repeat (g) step(1'b0, 1'b0, 1'b1, 1'b1);
          repeat (n2) step(bd, bi, 1'b1, 1'b1);
        end
        4: begin
          repeat (n) step(1'b1, 1'b0, 1'b1, 1'b1);
          repeat (n2) step(1'b1, 1'b1, 1'b1, 1'b1);
          repeat (n) step(1'b0, 1'b1, 1'b1, 1'b1);
        end
        default: begin
          repeat (n) step(bd, bi, 1'b1, 1'b1);
          do_reset($urandom_range(1, 3), bd, bi);
          repeat (n2) step(bd, bi, 1'b1, 1'b1);
        end
      endcase
      repeat ($urandom_range(0, 12)) step(1'b0, 1'b0, 1'b1, 1'b1);
    end

    repeat (20) step(1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    done = 1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected values left over, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
